// File: rtl/i2s_slave_rx.sv
// ---------------------------------------------------------------------------
// i2s_slave_rx
//
// I2S slave receiver. Deserialises an externally clocked Philips I2S stream
// (sck, ws, sd) into left/right sample pairs in the clk domain and presents
// one pair per stereo frame on a registered valid/ready output.
//
// Framing: ws low = left, ws high = right, MSB first, MSB one sck after each
// ws transition. DAT_WDTH data bits are left-justified in a SYS_WDTH slot;
// extra slot bits are ignored, missing LSBs of a short slot read as 0.
//
// Parameters
//   DAT_WDTH   sample bits per channel on the output (default 24)
//   SYS_WDTH   nominal bit slots per channel on the wire (default 32)
//
// Ports
//   clk         system clock, at least 6x the sck frequency
//   rst_n       asynchronous active-low reset
//   sck/ws/sd   I2S bit clock, word select, serial data (async to clk)
//   left_chan   left sample of the presented pair
//   right_chan  right sample of the presented pair
//   out_valid   pair available
//   out_ready   downstream accepts the pair
//   ovf         sticky overflow: a pair arrived while the output was stalled
//   ovf_clr     synchronous clear of ovf (and frame_err when present)
//   frame_err   (only with I2S_RX_FRAME_CHECK_EN) sticky, set when a kept
//               word did not span exactly SYS_WDTH sck periods
//
// Optional feature macro: I2S_RX_FRAME_CHECK_EN adds the frame_err port and
// the slot length comparison. Without it the block behaves identically minus
// that port.
//
// Output handshake: a beat transfers on a clk edge where out_valid and
// out_ready are both 1. While out_valid = 1 and out_ready = 0 the pair is
// held stable; a new pair arriving then is dropped and flags ovf. A new pair
// may load on the same edge the previous one is accepted.
// ---------------------------------------------------------------------------
module i2s_slave_rx #(
    parameter int DAT_WDTH = 24,
    parameter int SYS_WDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck,
    input  logic                ws,
    input  logic                sd,
    output logic [DAT_WDTH-1:0] left_chan,
    output logic [DAT_WDTH-1:0] right_chan,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ovf,
    input  logic                ovf_clr
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    output logic                frame_err
`endif
);

    // bcnt has to reach SYS_WDTH+1 so an over-long slot stays distinguishable.
    localparam int BW = $clog2(SYS_WDTH + 2);

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        RIGHT_WAIT = 2'd1,
        LEFT       = 2'd2,
        RIGHT      = 2'd3
    } state_t;

    state_t              state;
    logic [2:0]          sck_sync;   // [1] = sync2, [2] = sync3 (edge detect)
    logic [1:0]          ws_sync;
    logic [1:0]          sd_sync;
    logic                ws_q;       // ws seen at the previous sck rise
    logic [BW-1:0]       bcnt;
    logic [DAT_WDTH-1:0] word;
    logic [DAT_WDTH-1:0] left_hold;

    logic                rise;
    logic                ws_s;
    logic                sd_s;
    logic                word_end;
    logic [DAT_WDTH-1:0] word_full;  // word with the current bit merged in
    logic                pair_form;
    logic                load;

    assign rise = sck_sync[1] & ~sck_sync[2];
    assign ws_s = ws_sync[1];
    assign sd_s = sd_sync[1];

    always_comb begin
        word_end  = rise && (ws_s != ws_q);
        word_full = word;
        // Bit number bcnt lands at DAT_WDTH-1-bcnt; bcnt >= DAT_WDTH matches
        // no position, so trailing slot bits fall away.
        for (int i = 0; i < DAT_WDTH; i++) begin
            if (bcnt == BW'(DAT_WDTH - 1 - i)) begin
                word_full[i] = sd_s;
            end
        end
        pair_form = word_end && (state == RIGHT);
        load      = pair_form && (!out_valid || out_ready);
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic kept_word_end;
    assign kept_word_end = word_end && ((state == LEFT) || (state == RIGHT));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            sck_sync   <= '0;
            ws_sync    <= '0;
            sd_sync    <= '0;
            ws_q       <= 1'b0;
            bcnt       <= '0;
            word       <= '0;
            left_hold  <= '0;
            left_chan  <= '0;
            right_chan <= '0;
            out_valid  <= 1'b0;
            ovf        <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            ws_sync  <= {ws_sync[0], ws};
            sd_sync  <= {sd_sync[0], sd};

            if (rise) begin
                ws_q <= ws_s;
                if (word_end) begin
                    // The current bit closes the ws_q word; start a fresh slot.
                    bcnt <= '0;
                    word <= '0;
                    case (state)
                        SYNC:       state <= ws_s ? RIGHT_WAIT : LEFT;
                        RIGHT_WAIT: state <= LEFT;
                        LEFT: begin
                            left_hold <= word_full;
                            state     <= RIGHT;
                        end
                        RIGHT:      state <= LEFT;
                    endcase
                end else begin
                    word <= word_full;
                    if (bcnt != BW'(SYS_WDTH + 1)) begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
            end

            if (load) begin
                left_chan  <= left_hold;
                right_chan <= word_full;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end

            // Set has priority over clear.
            if (pair_form && !load) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

`ifdef I2S_RX_FRAME_CHECK_EN
            // bcnt+1 is the slot length in bits at its closing rise.
            if (kept_word_end && (bcnt != BW'(SYS_WDTH - 1))) begin
                frame_err <= 1'b1;
            end else if (ovf_clr) begin
                frame_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_slave_rx
//
// Self-checking bench for i2s_slave_rx (DAT_WDTH 24, SYS_WDTH 32). An I2S
// source model drives sck = clk/8 with ws/sd changing on the falling edge and
// the one-bit Philips delay. Every slot sent is logged; a reference model
// derives the expected pairs from that slot log (discard rules, left-justify,
// short-slot zero fill) and compares with the beats collected at the output.
// ---------------------------------------------------------------------------
module tb_i2s_slave_rx;

    localparam int DAT = 24;
    localparam int SYS = 32;

    // ---------------- clock / reset / DUT ----------------
    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           sck       = 1'b0;
    logic           ws        = 1'b0;
    logic           sd        = 1'b0;
    logic           out_ready = 1'b0;
    logic           ovf_clr   = 1'b0;
    logic [DAT-1:0] left_chan;
    logic [DAT-1:0] right_chan;
    logic           out_valid;
    logic           ovf;
`ifdef I2S_RX_FRAME_CHECK_EN
    logic           frame_err;
`endif

    always #5 clk = ~clk;

    i2s_slave_rx #(
        .DAT_WDTH (DAT),
        .SYS_WDTH (SYS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`ifdef I2S_RX_FRAME_CHECK_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    logic [2*DAT-1:0] exp_q[$];
    logic [2*DAT-1:0] got_q[$];
    logic             exp_ferr;

    // slot log since the last reset
    logic        slot_ch[$];
    logic [31:0] slot_lj[$];
    int          slot_n[$];

    logic prev_d  = 1'b0;
    logic last_ch = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({left_chan, right_chan});
        end
    end

    // Sample carried by a slot: the top DAT bits of the left-justified word,
    // with bits never transmitted forced to zero.
    function automatic logic [DAT-1:0] sample_of(input logic [31:0] lj, input int n);
        logic [31:0] s;
        s = lj >> (32 - DAT);
        if (n < DAT) begin
            s = (s >> (DAT - n)) << (DAT - n);
        end
        return s[DAT-1:0];
    endfunction

    // The first slot after reset is partial. Words are kept from the first
    // left slot that is not the first slot; a left slot pairs with the right
    // slot after it once that right slot has been closed by a following slot.
    task automatic build_expected();
        int start;
        exp_q.delete();
        exp_ferr = 1'b0;
        start    = -1;
        for (int i = 1; i < slot_ch.size(); i++) begin
            if (start < 0 && slot_ch[i] == 1'b0) start = i;
        end
        if (start > 0) begin
            for (int j = start; j + 1 < slot_ch.size(); j++) begin
                if (slot_n[j] != SYS) exp_ferr = 1'b1;
                if (slot_ch[j] == 1'b0 && j + 2 < slot_ch.size()) begin
                    exp_q.push_back({sample_of(slot_lj[j], slot_n[j]),
                                     sample_of(slot_lj[j+1], slot_n[j+1])});
                end
            end
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        build_expected();
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_pair"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
`ifdef I2S_RX_FRAME_CHECK_EN
        check({name, "_frame_err"}, 64'(frame_err), 64'(exp_ferr));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // One sck period: ws and sd change while sck is low; sd carries the bit
    // queued on the previous call (Philips one-bit delay).
    task automatic send_bit(input logic w, input logic d);
        ws     = w;
        sd     = prev_d;
        prev_d = d;
        #40 sck = 1'b1;
        #40 sck = 1'b0;
    endtask

    task automatic send_word(input logic ch, input logic [31:0] lj, input int nbits);
        logic b;
        slot_ch.push_back(ch);
        slot_lj.push_back(lj);
        slot_n.push_back(nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i < DAT) b = lj[31-i];
            else         b = 1'($urandom);
            send_bit(ch, b);
        end
        last_ch = ch;
    endtask

    // Two bits of the other channel: closes the last full word.
    task automatic flush();
        logic c;
        c = ~last_ch;
        slot_ch.push_back(c);
        slot_lj.push_back('0);
        slot_n.push_back(2);
        send_bit(c, 1'b0);
        send_bit(c, 1'b0);
        last_ch = c;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic begin_test(input string name);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        sck       = 1'b0;
        ws        = 1'b0;
        sd        = 1'b0;
        prev_d    = 1'b0;
        last_ch   = 1'b0;
        slot_ch.delete();
        slot_lj.delete();
        slot_n.delete();
        got_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check({name, "_rst_valid"}, 64'(out_valid), 64'(0));
        check({name, "_rst_pair"}, 64'({left_chan, right_chan}), 64'(0));
        check({name, "_rst_ovf"}, 64'(ovf), 64'(0));
`ifdef I2S_RX_FRAME_CHECK_EN
        check({name, "_rst_frame_err"}, 64'(frame_err), 64'(0));
`endif
        rst_n = 1'b1;
        // Keep every sck edge 2 ns after a clk rise, never on it.
        @(posedge clk);
        #2;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0]    l_lj;
        logic [31:0]    r_lj;
        int             nbits;
        logic [DAT-1:0] exp_l;
        logic [DAT-1:0] exp_r;
        logic           exp_ferr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] lv [4];
        logic [23:0] rv [4];
        logic        c;
        int          nb;

        tbl[0] = '{32'hA5A5A500, 32'h12345600, 32, 24'hA5A5A5, 24'h123456, 1'b0};
        tbl[1] = '{32'hBEEF0000, 32'hCAFE0000, 16, 24'hBEEF00, 24'hCAFE00, 1'b1};
        tbl[2] = '{32'hFFFFFF00, 32'h00000100, 32, 24'hFFFFFF, 24'h000001, 1'b0};
        tbl[3] = '{32'h80000000, 32'h7FFFFF00, 24, 24'h800000, 24'h7FFFFF, 1'b1};
        tbl[4] = '{32'hC3C3C300, 32'h3C3C3C00, 33, 24'hC3C3C3, 24'h3C3C3C, 1'b1};

        // Three identical frames per row: the first is lost to sync, two beats follow.
        for (int r = 0; r < 5; r++) begin
            begin_test("table");
            for (int f = 0; f < 3; f++) begin
                send_word(1'b0, tbl[r].l_lj, tbl[r].nbits);
                send_word(1'b1, tbl[r].r_lj, tbl[r].nbits);
            end
            flush();
            check("table_beats", 64'(got_q.size()), 64'(2));
            for (int i = 0; i < got_q.size(); i++) begin
                check("table_pair", 64'(got_q[i]), 64'({tbl[r].exp_l, tbl[r].exp_r}));
            end
            check("table_ovf", 64'(ovf), 64'(0));
`ifdef I2S_RX_FRAME_CHECK_EN
            check("table_frame_err", 64'(frame_err), 64'(tbl[r].exp_ferr));
`endif
            compare_stream("table_model");
        end

        // Random values, random start channel, occasional odd slot lengths.
        for (int r = 0; r < 3; r++) begin
            begin_test("rand");
            c = 1'($urandom_range(0, 1));
            for (int s = 0; s < 8; s++) begin
                nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 34)) : SYS;
                send_word(c, $urandom, nb);
                c = ~c;
            end
            flush();
            check("rand_ovf", 64'(ovf), 64'(0));
            compare_stream("rand_model");
        end

        // Backpressure across two frames: first pair held, second dropped.
        begin_test("bp");
        out_ready = 1'b0;
        send_word(1'b0, $urandom, SYS);
        send_word(1'b1, $urandom, SYS);
        send_word(1'b0, {24'h111111, 8'h00}, SYS);
        send_word(1'b1, {24'h222222, 8'h00}, SYS);
        send_word(1'b0, {24'h333333, 8'h00}, SYS);
        send_word(1'b1, {24'h444444, 8'h00}, SYS);
        flush();
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_held_pair", 64'({left_chan, right_chan}), 64'({24'h111111, 24'h222222}));
        check("bp_ovf_set", 64'(ovf), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_one_beat", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("bp_beat_pair", 64'(got_q[0]), 64'({24'h111111, 24'h222222}));
        check("bp_valid_clr", 64'(out_valid), 64'(0));
        check("bp_ovf_sticky", 64'(ovf), 64'(1));
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        check("bp_ovf_clr", 64'(ovf), 64'(0));

        // out_ready rises exactly on the edge the second pair forms.
        begin_test("same");
        out_ready = 1'b0;
        send_word(1'b0, $urandom, SYS);
        send_word(1'b1, $urandom, SYS);
        send_word(1'b0, {24'hABCDEF, 8'h00}, SYS);
        send_word(1'b1, {24'h13579B, 8'h00}, SYS);
        send_word(1'b0, {24'h2468AC, 8'h00}, SYS);
        send_word(1'b1, {24'hFEDCBA, 8'h00}, SYS);
        // Closing bit of the right word, timed by hand: the pair forms on the
        // third clk edge after sck rises.
        ws     = 1'b0;
        sd     = prev_d;
        prev_d = 1'b0;
        #40 sck = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("same_valid", 64'(out_valid), 64'(1));
        check("same_new_pair", 64'({left_chan, right_chan}), 64'({24'h2468AC, 24'hFEDCBA}));
        check("same_ovf", 64'(ovf), 64'(0));
        check("same_beats", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("same_old_pair", 64'(got_q[0]), 64'({24'hABCDEF, 24'h13579B}));
        #11 sck = 1'b0;

        // Reset in the middle of a right word.
        begin_test("rstmid");
        out_ready = 1'b0;
        send_word(1'b0, $urandom, SYS);
        send_word(1'b1, $urandom, SYS);
        send_word(1'b0, $urandom, SYS);
        send_word(1'b1, $urandom, SYS);
        send_word(1'b0, $urandom, SYS);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'($urandom));
        check("rstmid_valid_before", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rstmid_valid_now", 64'(out_valid), 64'(0));
        check("rstmid_pair_now", 64'({left_chan, right_chan}), 64'(0));
        slot_ch.delete();
        slot_lj.delete();
        slot_n.delete();
        got_q.delete();
        #29 rst_n = 1'b1;
        #10 out_ready = 1'b1;
        slot_ch.push_back(1'b1);
        slot_lj.push_back('0);
        slot_n.push_back(20);
        for (int i = 12; i < 32; i++) send_bit(1'b1, 1'($urandom));
        last_ch = 1'b1;
        send_word(1'b0, {24'h0F0F0F, 8'h00}, SYS);
        send_word(1'b1, {24'hF0F0F0, 8'h00}, SYS);
        flush();
        check("rstmid_beats", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("rstmid_pair", 64'(got_q[0]), 64'({24'h0F0F0F, 24'hF0F0F0}));
        compare_stream("rstmid_model");

        // Stream starting with ws high: the leading right word is discarded.
        begin_test("mono");
        for (int k = 0; k < 4; k++) begin
            lv[k] = 24'h100000 + 24'(k);
            rv[k] = 24'h200000 + 24'(k);
        end
        send_word(1'b1, $urandom, SYS);
        for (int k = 0; k < 4; k++) begin
            send_word(1'b0, {lv[k], 8'h00}, SYS);
            send_word(1'b1, {rv[k], 8'h00}, SYS);
        end
        flush();
        check("mono_beats", 64'(got_q.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) check("mono_pair", 64'(got_q[k]), 64'({lv[k], rv[k]}));
        end
        compare_stream("mono_model");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
- I2S slave receiver, the counterpart of our I2S slave transmitter. It deserialises an externally clocked I2S stream (sck, ws, sd) into parallel left/right sample pairs in the system clock domain.
- Sits between the external I2S source (ADC/codec) and downstream audio processing.
- Output is a registered valid/ready stream, one beat per stereo frame.
- Standard Philips framing: ws low = left, ws high = right, MSB first, MSB one sck after each ws transition, DAT_WDTH data bits left-justified in a SYS_WDTH slot.

Parameters:
- DAT_WDTH, 24, sample bits per channel delivered on the output.
- SYS_WDTH, 32, nominal bit slots per channel on the wire (DAT_WDTH <= SYS_WDTH).

Ports:
- clk  input  1  system clock; frequency >= 6x sck frequency.
- rst_n  input  1  asynchronous active-low reset.
- sck  input  1  I2S bit clock, asynchronous to clk.
- ws  input  1  I2S word select, asynchronous to clk.
- sd  input  1  I2S serial data, asynchronous to clk.
- left_chan  output  DAT_WDTH  left sample of the presented pair.
- right_chan  output  DAT_WDTH  right sample of the presented pair.
- out_valid  output  1  pair available.
- out_ready  input  1  downstream accepts the pair.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset values: all outputs 0; internal state SYNC; synchronisers, counters and holds cleared.
- Synchronisation:
  - sck, ws and sd each pass through two flops; sck gets a third flop for edge detect.
  - A sck rise is detected when sync2 = 1 and sync3 = 0.
  - ws and sd are taken from their sync2 stage, so they are aligned with the sck rise.
- Per detected sck rise:
  - Sample ws_s and sd_s.
  - ws_q holds ws_s from the previous rise.
  - The sd bit belongs to channel ws_q (one-bit I2S delay).
- Word assembly:
  - A bit counter bcnt counts bits of the current slot.
  - While bcnt < DAT_WDTH, the bit is stored at position DAT_WDTH-1-bcnt of the word register.
  - Bits at bcnt >= DAT_WDTH are ignored.
  - bcnt saturates at SYS_WDTH+1.
- Word end is the rise where ws_s != ws_q:
  - The current bit is the last bit of the ws_q channel.
  - The word is completed with that bit included.
  - Then bcnt is reset to 0 and the word register is cleared.
  - Unreceived LSBs of a short slot are 0.
- State machine:
  - SYNC: ignore data until the first word end, which is discarded as partial. Then go to LEFT if ws_s = 0, else RIGHT_WAIT.
  - RIGHT_WAIT: at the next word end (a right word), discard it and go to LEFT.
  - LEFT: at word end, copy the word to left_hold and go to RIGHT.
  - RIGHT: at word end, form the pair {left_hold, word} and go to LEFT.
- Output register:
  - A pair formed while out_valid = 0, or while out_valid = 1 and out_ready = 1 in the same cycle, loads left_chan/right_chan and sets out_valid.
  - A pair formed while out_valid = 1 and out_ready = 0 is dropped. Outputs stay unchanged and ovf is set.
  - out_valid clears on out_ready when no new pair loads that cycle.
  - Outputs are stable while out_valid = 1 and out_ready = 0.
- Latency: out_valid rises on the third clk edge, counting the first clk edge that samples sck high at the right word end as edge 1.
- ovf:
  - Set by an overflow; cleared by ovf_clr.
  - Set wins over clear in the same cycle.
- Reset mid-frame: immediate return to SYNC. The partial frame is lost and no spurious pair is produced after reset release.

Optional Feature:
- Macro I2S_RX_FRAME_CHECK_EN.
- When defined:
  - Add output frame_err (1 bit, reset 0, sticky, cleared by ovf_clr).
  - frame_err is set when any non-discarded word end occurs with bcnt+1 != SYS_WDTH.
  - The offending pair is still delivered.
- When undefined:
  - No frame_err port and no length comparison.
  - Other behaviour is identical.

Test Plan:
- Startup, DAT 24/SYS 32, sck = clk/8: transmit left 0xA5A5A5, right 0x123456 for 3 frames. The first (partial) frame is discarded; then exactly 2 beats, each with left_chan = 0xA5A5A5 and right_chan = 0x123456, and ovf = 0.
- Backpressure: hold out_ready = 0 across two complete frames (0x111111/0x222222, then 0x333333/0x444444). Outputs remain 0x111111/0x222222 and ovf = 1. After out_ready = 1, a single beat is accepted; ovf_clr then clears ovf.
- Same-cycle accept and load: drive out_ready high exactly on the cycle the next pair forms. The new pair loads, out_valid stays 1 and ovf stays 0.
- Short slot (16 bits per channel, left 0xBEEF, right 0xCAFE): left_chan = 0xBEEF00, right_chan = 0xCAFE00. With I2S_RX_FRAME_CHECK_EN, frame_err = 1; without it, no error port.
- Reset asserted mid right word: out_valid = 0 immediately. After release, the first full frame (0x0F0F0F/0xF0F0F0) following a discarded partial frame is delivered correctly.
- Mono-sourced stream starting with ws high: the first right word is discarded in RIGHT_WAIT. Pairing stays left-then-right, with no swapped channels across 4 frames of incrementing values.
